// File: rtl/anti_theft_fsm_pkg.sv
// ---------------------------------------------------------------------------
// anti_theft_fsm_pkg
// Shared definitions for the anti-theft controller slice:
//   - state_t     : controller state codes (also driven on fsm_state)
//   - param_sel_t : interval selector codes used by reprogram and the timer
//   - DEF_T_*     : reset values of the four stored intervals (seconds)
//   - is_timed_state : states that program the countdown timer on entry
// ---------------------------------------------------------------------------
package anti_theft_fsm_pkg;

    typedef enum logic [2:0] {
        ST_DISARMED   = 3'd0,
        ST_WAIT_OPEN  = 3'd1,
        ST_WAIT_CLOSE = 3'd2,
        ST_ARM_DELAY  = 3'd3,
        ST_ARMED      = 3'd4,
        ST_TRIGGERED  = 3'd5,
        ST_ALARM      = 3'd6,
        ST_ALARM_HOLD = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SEL_ARM       = 2'd0,
        SEL_DRIVER    = 2'd1,
        SEL_PASSENGER = 2'd2,
        SEL_ALARM_ON  = 2'd3
    } param_sel_t;

    localparam logic [3:0] DEF_T_ARM       = 4'd6;
    localparam logic [3:0] DEF_T_DRIVER    = 4'd8;
    localparam logic [3:0] DEF_T_PASSENGER = 4'd15;
    localparam logic [3:0] DEF_T_ALARM     = 4'd10;

    // States whose entry launches a fresh countdown on the external timer.
    function automatic logic is_timed_state(input state_t s);
        return (s == ST_ARM_DELAY) || (s == ST_TRIGGERED) || (s == ST_ALARM_HOLD);
    endfunction

endpackage

// File: rtl/anti_theft_fsm_time_param_regs.sv
// ---------------------------------------------------------------------------
// anti_theft_fsm_time_param_regs
// Four 4-bit interval registers (arm, driver, passenger, alarm_on), each
// reset to its own default, written synchronously on write_en, read through
// a combinational mux.
// Ports:
//   clock, reset          : clock, asynchronous active-low reset
//   write_en              : write write_value into entry write_sel
//   write_sel, write_value: target entry and data
//   read_sel              : entry presented on read_value
//   read_value            : selected interval
// ---------------------------------------------------------------------------
module anti_theft_fsm_time_param_regs
    import anti_theft_fsm_pkg::*;
#(
    parameter logic [3:0] T_ARM_DEFAULT       = DEF_T_ARM,
    parameter logic [3:0] T_DRIVER_DEFAULT    = DEF_T_DRIVER,
    parameter logic [3:0] T_PASSENGER_DEFAULT = DEF_T_PASSENGER,
    parameter logic [3:0] T_ALARM_DEFAULT     = DEF_T_ALARM
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_en,
    input  logic [1:0] write_sel,
    input  logic [3:0] write_value,
    input  logic [1:0] read_sel,
    output logic [3:0] read_value
);

    logic [3:0] intervals [4];

    // Each entry comes out of reset with its own default interval.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            intervals[SEL_ARM]       <= T_ARM_DEFAULT;
            intervals[SEL_DRIVER]    <= T_DRIVER_DEFAULT;
            intervals[SEL_PASSENGER] <= T_PASSENGER_DEFAULT;
            intervals[SEL_ALARM_ON]  <= T_ALARM_DEFAULT;
        end else if (write_en) begin
            intervals[write_sel] <= write_value;
        end
    end

    assign read_value = intervals[read_sel];

endmodule

// File: rtl/anti_theft_fsm.sv
// ---------------------------------------------------------------------------
// anti_theft_fsm
// Arm / trigger / alarm sequencing controller. Programs the external
// countdown timer with a start pulse plus interval, and drives the siren and
// status LED from the timer's expired / 1 Hz / 2 Hz enables.
// Ports:
//   clock, reset                  : clock, asynchronous active-low reset
//   ignition, driver_door,
//   passenger_door                : vehicle inputs (already synchronised)
//   reprogram, time_param_sel,
//   time_value                    : interval write port (forces ARMED)
//   expired, one_hz_enable,
//   two_hz_enable                 : from the timer
//   start_timer, timer_value      : registered start pulse and interval
//   siren, status_led             : registered indicators
//   fsm_state                     : current state code (debug)
// ---------------------------------------------------------------------------
module anti_theft_fsm
    import anti_theft_fsm_pkg::*;
#(
    parameter logic [3:0] T_ARM_DEFAULT       = DEF_T_ARM,
    parameter logic [3:0] T_DRIVER_DEFAULT    = DEF_T_DRIVER,
    parameter logic [3:0] T_PASSENGER_DEFAULT = DEF_T_PASSENGER,
    parameter logic [3:0] T_ALARM_DEFAULT     = DEF_T_ALARM
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ignition,
    input  logic       driver_door,
    input  logic       passenger_door,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       expired,
    input  logic       one_hz_enable,
    input  logic       two_hz_enable,
    output logic       start_timer,
    output logic [3:0] timer_value,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] fsm_state
);

    state_t     state;
    state_t     next_state;
    param_sel_t timer_sel;
    logic [3:0] interval;
    logic       any_door;
    logic       expired_ok;
    logic       start_next;
    logic [3:0] value_next;
    logic       siren_next;
    logic       led_next;

    anti_theft_fsm_time_param_regs #(
        .T_ARM_DEFAULT       (T_ARM_DEFAULT),
        .T_DRIVER_DEFAULT    (T_DRIVER_DEFAULT),
        .T_PASSENGER_DEFAULT (T_PASSENGER_DEFAULT),
        .T_ALARM_DEFAULT     (T_ALARM_DEFAULT)
    ) u_time_param_regs (
        .clock       (clock),
        .reset       (reset),
        .write_en    (reprogram),
        .write_sel   (time_param_sel),
        .write_value (time_value),
        .read_sel    (timer_sel),
        .read_value  (interval)
    );

    assign any_door = driver_door | passenger_door;
    // While the start pulse is out the timer has not yet cleared its old
    // expiry, so expired is stale for that cycle.
    assign expired_ok = expired & ~start_timer;
    assign fsm_state  = state;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_ARMED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Priority: reprogram > ignition > doors > expired.
    // timer_sel picks the interval that goes with the state being entered.
    always_comb begin
        next_state = state;
        timer_sel  = SEL_ARM;
        if (reprogram) begin
            next_state = ST_ARMED;
        end else begin
            case (state)
                ST_DISARMED: begin
                    if (!ignition) next_state = ST_WAIT_OPEN;
                end
                ST_WAIT_OPEN: begin
                    if (ignition)         next_state = ST_DISARMED;
                    else if (driver_door) next_state = ST_WAIT_CLOSE;
                end
                ST_WAIT_CLOSE: begin
                    timer_sel = SEL_ARM;
                    if (ignition)          next_state = ST_DISARMED;
                    else if (!driver_door) next_state = ST_ARM_DELAY;
                end
                ST_ARM_DELAY: begin
                    timer_sel = SEL_ARM;
                    if (ignition)        next_state = ST_DISARMED;
                    else if (any_door)   next_state = ST_WAIT_CLOSE;
                    else if (expired_ok) next_state = ST_ARMED;
                end
                ST_ARMED: begin
                    if (driver_door) begin
                        next_state = ST_TRIGGERED;
                        timer_sel  = SEL_DRIVER;
                    end else if (passenger_door) begin
                        next_state = ST_TRIGGERED;
                        timer_sel  = SEL_PASSENGER;
                    end
                end
                ST_TRIGGERED: begin
                    if (ignition)        next_state = ST_DISARMED;
                    else if (expired_ok) next_state = ST_ALARM;
                end
                ST_ALARM: begin
                    timer_sel = SEL_ALARM_ON;
                    if (ignition)       next_state = ST_DISARMED;
                    else if (!any_door) next_state = ST_ALARM_HOLD;
                end
                ST_ALARM_HOLD: begin
                    if (ignition)        next_state = ST_DISARMED;
                    else if (any_door)   next_state = ST_ALARM;
                    else if (expired_ok) next_state = ST_ARMED;
                end
                default: next_state = ST_ARMED;
            endcase
        end
    end

    // Output next-values. A start pulse accompanies every entry into a timed
    // state; the LED restarts from 0 on any state change and otherwise
    // toggles at the rate that belongs to the current state.
    always_comb begin
        start_next = (next_state != state) && is_timed_state(next_state);
        value_next = start_next ? interval : timer_value;
        siren_next = (state == ST_ALARM) || (state == ST_ALARM_HOLD);
        led_next   = 1'b0;
        if (next_state == state) begin
            case (state)
                ST_ARMED:      led_next = status_led ^ one_hz_enable;
                ST_TRIGGERED,
                ST_ALARM,
                ST_ALARM_HOLD: led_next = status_led ^ two_hz_enable;
                default:       led_next = 1'b0;
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_timer <= 1'b0;
            timer_value <= 4'd0;
            siren       <= 1'b0;
            status_led  <= 1'b0;
        end else begin
            start_timer <= start_next;
            timer_value <= value_next;
            siren       <= siren_next;
            status_led  <= led_next;
        end
    end

endmodule

// File: tb/tb_anti_theft_fsm.sv
// ---------------------------------------------------------------------------
// tb_anti_theft_fsm
// Directed walk through the arm / trigger / alarm / disarm paths followed by
// a randomized run, all compared cycle by cycle against a behavioural model.
// ---------------------------------------------------------------------------
module tb_anti_theft_fsm;
    import anti_theft_fsm_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ignition = 1'b0;
    logic       driver_door = 1'b0;
    logic       passenger_door = 1'b0;
    logic       reprogram = 1'b0;
    logic [1:0] time_param_sel = 2'd0;
    logic [3:0] time_value = 4'd0;
    logic       expired = 1'b0;
    logic       one_hz_enable = 1'b0;
    logic       two_hz_enable = 1'b0;
    logic       start_timer;
    logic [3:0] timer_value;
    logic       siren;
    logic       status_led;
    logic [2:0] fsm_state;

    int total = 0;
    int bad   = 0;

    anti_theft_fsm dut (
        .clock          (clock),
        .reset          (reset),
        .ignition       (ignition),
        .driver_door    (driver_door),
        .passenger_door (passenger_door),
        .reprogram      (reprogram),
        .time_param_sel (time_param_sel),
        .time_value     (time_value),
        .expired        (expired),
        .one_hz_enable  (one_hz_enable),
        .two_hz_enable  (two_hz_enable),
        .start_timer    (start_timer),
        .timer_value    (timer_value),
        .siren          (siren),
        .status_led     (status_led),
        .fsm_state      (fsm_state)
    );

    always #5 clock = ~clock;

    // Behavioural model state: current mode, pending start pulse, interval
    // on the timer bus, siren, enable pulses counted since entering the mode
    // and the stored interval table.
    state_t     m_state;
    bit         m_start;
    logic [3:0] m_tv;
    bit         m_siren;
    int         m_pulses;
    logic [3:0] m_int [4];

    function automatic bit fast_blink(input state_t s);
        return (s == ST_TRIGGERED) || (s == ST_ALARM) || (s == ST_ALARM_HOLD);
    endfunction

    task automatic model_reset();
        m_state  = ST_ARMED;
        m_start  = 1'b0;
        m_tv     = 4'd0;
        m_siren  = 1'b0;
        m_pulses = 0;
        m_int[0] = 4'd6;
        m_int[1] = 4'd8;
        m_int[2] = 4'd15;
        m_int[3] = 4'd10;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_step();
        state_t cur;
        state_t nxt;
        int     sel;
        bit     door_any;
        bit     exp_q;
        cur      = m_state;
        nxt      = cur;
        sel      = 0;
        door_any = driver_door || passenger_door;
        exp_q    = expired && !m_start;
        if (reprogram) begin
            nxt = ST_ARMED;
        end else if (cur == ST_ARMED) begin
            if (driver_door) begin
                nxt = ST_TRIGGERED; sel = 1;
            end else if (passenger_door) begin
                nxt = ST_TRIGGERED; sel = 2;
            end
        end else if (cur == ST_DISARMED) begin
            if (!ignition) nxt = ST_WAIT_OPEN;
        end else if (ignition) begin
            nxt = ST_DISARMED;
        end else begin
            case (cur)
                ST_WAIT_OPEN:  if (driver_door) nxt = ST_WAIT_CLOSE;
                ST_WAIT_CLOSE: if (!driver_door) begin nxt = ST_ARM_DELAY; sel = 0; end
                ST_ARM_DELAY:  if (door_any) nxt = ST_WAIT_CLOSE; else if (exp_q) nxt = ST_ARMED;
                ST_TRIGGERED:  if (exp_q) nxt = ST_ALARM;
                ST_ALARM:      if (!door_any) begin nxt = ST_ALARM_HOLD; sel = 3; end
                ST_ALARM_HOLD: if (door_any) nxt = ST_ALARM; else if (exp_q) nxt = ST_ARMED;
                default: ;
            endcase
        end
        m_siren = (cur == ST_ALARM) || (cur == ST_ALARM_HOLD);
        if (nxt != cur) m_pulses = 0;
        else if (cur == ST_ARMED && one_hz_enable) m_pulses++;
        else if (fast_blink(cur) && two_hz_enable) m_pulses++;
        m_start = (nxt != cur) &&
                  (nxt == ST_ARM_DELAY || nxt == ST_TRIGGERED || nxt == ST_ALARM_HOLD);
        if (m_start) m_tv = m_int[sel];
        if (reprogram) m_int[time_param_sel] = time_value;
        m_state = nxt;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit exp_led;
        exp_led = (m_state == ST_ARMED || fast_blink(m_state)) ? m_pulses[0] : 1'b0;
        check("fsm_state",   {1'b0, fsm_state},   {1'b0, m_state});
        check("start_timer", {3'b0, start_timer}, {3'b0, m_start});
        check("timer_value", timer_value,         m_tv);
        check("siren",       {3'b0, siren},       {3'b0, m_siren});
        check("status_led",  {3'b0, status_led},  {3'b0, exp_led});
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(input bit ign, input bit dd, input bit pd,
                                 input bit ex, input bit one, input bit two);
        ignition       = ign;
        driver_door    = dd;
        passenger_door = pd;
        expired        = ex;
        one_hz_enable  = one;
        two_hz_enable  = two;
        reprogram      = 1'b0;
        tick();
    endtask

    task automatic applyReprogram(input logic [1:0] sel, input logic [3:0] val);
        reprogram      = 1'b1;
        time_param_sel = sel;
        time_value     = val;
        expired        = 1'b0;
        one_hz_enable  = 1'b0;
        two_hz_enable  = 1'b0;
        tick();
        reprogram      = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_state", {1'b0, fsm_state}, {1'b0, ST_ARMED});
        check("rst_siren", {3'b0, siren}, 4'd0);
        reset = 1'b1;

        // ARMED: three 1 Hz pulses blink the LED 1,0,1
        applyStimulus(0, 0, 0, 0, 1, 0); check("led_1", {3'b0, status_led}, 4'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0); check("led_2", {3'b0, status_led}, 4'd0);
        applyStimulus(0, 0, 0, 0, 1, 0); check("led_3", {3'b0, status_led}, 4'd1);

        // Driver door -> TRIGGERED with driver interval, then ALARM
        applyStimulus(0, 1, 0, 0, 0, 0);
        check("trig_state", {1'b0, fsm_state}, {1'b0, ST_TRIGGERED});
        check("trig_start", {3'b0, start_timer}, 4'd1);
        check("trig_tv", timer_value, 4'd8);
        applyStimulus(0, 1, 0, 0, 0, 1);
        check("trig_pulse_once", {3'b0, start_timer}, 4'd0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        check("alarm_state", {1'b0, fsm_state}, {1'b0, ST_ALARM});
        applyStimulus(0, 1, 0, 0, 0, 1);
        check("alarm_siren", {3'b0, siren}, 4'd1);

        // ALARM_HOLD entry, re-entry and expiry
        applyStimulus(0, 0, 0, 0, 0, 0);
        check("hold_tv", timer_value, 4'd10);
        check("hold_start", {3'b0, start_timer}, 4'd1);
        applyStimulus(0, 0, 1, 0, 0, 0);
        check("hold_reopen", {1'b0, fsm_state}, {1'b0, ST_ALARM});
        applyStimulus(0, 0, 0, 0, 0, 0);
        check("hold_restart", {3'b0, start_timer}, 4'd1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        check("hold_expire", {1'b0, fsm_state}, {1'b0, ST_ARMED});
        applyStimulus(0, 0, 0, 0, 0, 0);
        check("siren_off", {3'b0, siren}, 4'd0);

        // Both doors -> driver interval; ignition in TRIGGERED disarms
        applyStimulus(0, 1, 1, 0, 0, 0);
        check("both_tv", timer_value, 4'd8);
        applyStimulus(1, 0, 0, 0, 0, 0);
        check("disarm", {1'b0, fsm_state}, {1'b0, ST_DISARMED});
        applyStimulus(1, 0, 0, 0, 0, 0);
        check("disarm_siren", {3'b0, siren}, 4'd0);

        // Arming path with door reopen and stale expiry
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        check("armdly_tv", timer_value, 4'd6);
        applyStimulus(0, 0, 1, 0, 0, 0);
        check("armdly_reopen", {1'b0, fsm_state}, {1'b0, ST_WAIT_CLOSE});
        applyStimulus(0, 0, 0, 0, 0, 0);
        check("armdly_restart", {3'b0, start_timer}, 4'd1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        check("stale_expired", {1'b0, fsm_state}, {1'b0, ST_ARM_DELAY});
        applyStimulus(0, 0, 0, 1, 0, 0);
        check("armed_again", {1'b0, fsm_state}, {1'b0, ST_ARMED});

        // Passenger only -> passenger interval
        applyStimulus(0, 0, 1, 0, 0, 0);
        check("pass_tv", timer_value, 4'd15);
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);

        // Reprogram during ALARM forces ARMED and takes effect on next trigger
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyReprogram(2'd1, 4'd3);
        check("reprog_state", {1'b0, fsm_state}, {1'b0, ST_ARMED});
        applyStimulus(0, 1, 0, 0, 0, 0);
        check("reprog_tv", timer_value, 4'd3);
        check("reprog_siren", {3'b0, siren}, 4'd0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        check("pre_rst_hold", {1'b0, fsm_state}, {1'b0, ST_ALARM_HOLD});

        // Asynchronous reset in the middle of ALARM_HOLD
        #2 reset = 1'b0;
        #1;
        model_reset();
        checkOutput();
        #1 reset = 1'b1;
        applyStimulus(0, 1, 0, 0, 0, 0);
        check("post_rst_tv", timer_value, 4'd8);

        // Randomized run
        begin
            bit ign_l = 0, dd_l = 0, pd_l = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 15) == 0) ign_l = ~ign_l;
                if ($urandom_range(0, 5) == 0)  dd_l  = ~dd_l;
                if ($urandom_range(0, 5) == 0)  pd_l  = ~pd_l;
                if ($urandom_range(0, 49) == 0) begin
                    ignition = ign_l; driver_door = dd_l; passenger_door = pd_l;
                    applyReprogram(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
                end else begin
                    applyStimulus(ign_l, dd_l, pd_l,
                                  $urandom_range(0, 4) == 0,
                                  $urandom_range(0, 3) == 0,
                                  $urandom_range(0, 2) == 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/anti_theft_fsm.md
Name: anti_theft_fsm

Overview:
Top-level sequencing controller for the automotive anti-theft system. It watches ignition and door inputs and walks the arm, trigger and alarm state machine. It programs the countdown timer with one of four stored intervals via a start pulse, and consumes the timer's expired, 1 Hz and 2 Hz enables to drive the siren and the status LED.

Parameters:
T_ARM_DEFAULT, 6, reset value of arm-delay interval (s)
T_DRIVER_DEFAULT, 8, reset value of driver-door delay interval
T_PASSENGER_DEFAULT, 15, reset value of passenger-door delay interval
T_ALARM_DEFAULT, 10, reset value of alarm-on hold interval

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
ignition  in  1  ignition on (synchronised/debounced upstream)
driver_door  in  1  1 = driver door open
passenger_door  in  1  1 = any passenger door open
reprogram  in  1  one-cycle pulse: write time_value into interval selected by time_param_sel
time_param_sel  in  2  00 arm, 01 driver, 10 passenger, 11 alarm_on
time_value  in  4  interval to store
expired  in  1  from timer
one_hz_enable  in  1  from timer, 1-cycle pulse
two_hz_enable  in  1  from timer, 1-cycle pulse
start_timer  out  1  registered 1-cycle pulse to timer
timer_value  out  4  registered interval presented with start_timer
siren  out  1  registered siren drive
status_led  out  1  registered status indicator
fsm_state  out  3  current state code (debug)

Behaviour:
- Reset (reset=0, async): state ARMED; intervals = defaults; start_timer, timer_value, siren, status_led = 0.
- States: DISARMED, WAIT_OPEN, WAIT_CLOSE, ARM_DELAY, ARMED, TRIGGERED, ALARM, ALARM_HOLD.
- Priority each cycle: reprogram > ignition > doors > expired.
- reprogram=1: write register; next state ARMED from any state; no start pulse.
- DISARMED: ignition=0 -> WAIT_OPEN.
- WAIT_OPEN: ignition -> DISARMED; driver_door -> WAIT_CLOSE.
- WAIT_CLOSE: ignition -> DISARMED; driver_door=0 -> ARM_DELAY.
- ARM_DELAY: ignition -> DISARMED; any door=1 -> WAIT_CLOSE; expired -> ARMED.
- ARMED: driver_door -> TRIGGERED with driver interval. Else passenger_door -> TRIGGERED with passenger interval. Driver wins if both doors open. Ignition is ignored.
- TRIGGERED: ignition -> DISARMED; expired -> ALARM.
- ALARM: ignition -> DISARMED; both doors closed -> ALARM_HOLD.
- ALARM_HOLD: ignition -> DISARMED; any door open -> ALARM; expired -> ARMED.
- start_timer: high for exactly the first cycle after entering ARM_DELAY (arm interval), TRIGGERED (driver/passenger interval) or ALARM_HOLD (alarm_on interval).
  - Every entry issues a fresh pulse, including re-entry.
  - timer_value is updated in the same cycle and held until the next pulse.
- expired is qualified: it is ignored while start_timer=1, because it is stale until the timer clears it. It is also ignored in all states other than ARM_DELAY, TRIGGERED and ALARM_HOLD.
- Expiry latency is owned by the timer; the controller applies no compensation. Value 0 is stored and used as-is.
- siren = 1 in ALARM and ALARM_HOLD, else 0. It updates one cycle after the state change.
- status_led:
  - ARMED: toggles on each one_hz_enable.
  - TRIGGERED, ALARM, ALARM_HOLD: toggles on each two_hz_enable.
  - All other states: forced 0.
  - On entry to a blinking state, status_led starts from 0.
- Reset mid-countdown returns to ARMED. The timer keeps running, and its stale expired is ignored in ARMED.

Decomposition:
- Shared include antitheft_defs.vh: state codes, time_param_sel codes, default interval constants.
- Sub-module time_param_regs: 4x4-bit register file with per-entry reset defaults, synchronous write on reprogram, combinational read mux by select.

Test Plan:
- Reset release -> fsm_state=ARMED, siren=0; 3 one_hz_enable pulses -> status_led sequence 1,0,1.
- ARMED, driver_door=1 -> next cycle TRIGGERED, start_timer=1 for 1 cycle, timer_value=8; expired=1 -> ALARM, siren=1.
- ARMED, both doors=1 -> timer_value=8 (driver priority); passenger only -> timer_value=15; ignition=1 in TRIGGERED -> DISARMED, no siren.
- ALARM, doors close -> ALARM_HOLD, start pulse with value 10; door reopens -> ALARM; close again -> second start pulse; expired -> ARMED, siren=0.
- Disarm path: ignition 1->0, driver_door 1->0 -> ARM_DELAY with value 6. Passenger door open -> WAIT_CLOSE, then close -> second pulse with value 6. Expired held high during the start cycle -> no transition; expired one cycle after the pulse -> ARMED.
- reprogram sel=01 value=3 while in ALARM -> ARMED, siren=0; subsequent driver_door -> timer_value=3; async reset mid-ALARM_HOLD -> ARMED, intervals back to defaults.
